// File: rtl/led_scan_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_scan_ctrl_if                                                         |
// | Slot strobes in, FIFO/panel scan controls out, for led_scan_ctrl.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface led_scan_ctrl_if #(
  parameter int ROW_W = 4
);
  logic             en;
  logic             pwm_cntr_strobe;
  logic             alrst_strobe;
  logic [7:0]       pwm_value;
  logic             al_re_n;
  logic             al_rrst_n;
  logic             panel_clk_en;
  logic             led_lat;
  logic             led_oe_n;
  logic [ROW_W-1:0] row_addr;
  logic             frame_done;

  modport master (
    input  en, pwm_cntr_strobe, alrst_strobe,
    output pwm_value, al_re_n, al_rrst_n, panel_clk_en, led_lat, led_oe_n,
           row_addr, frame_done
  );

  modport slave (
    output en, pwm_cntr_strobe, alrst_strobe,
    input  pwm_value, al_re_n, al_rrst_n, panel_clk_en, led_lat, led_oe_n,
           row_addr, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/led_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_scan_ctrl                                                            |
// | HUB75 scan sequencer: FIFO rewind/read, shift, latch, row and PWM step.  |
// | Option macro: LED_SCAN_ANTIGHOST_EN (3-slot latch, row moves in slot B). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module led_scan_ctrl #(
  parameter int COLS    = 64,
  parameter int ROW_W   = 4,
  parameter int PWM_MAX = 254
) (
  input  logic           in_clk,
  input  logic           in_nrst,
  led_scan_ctrl_if.master scan
);
  localparam int ROWS = 2**ROW_W;
`ifdef LED_SCAN_ANTIGHOST_EN
  localparam logic [1:0] c_lat_last = 2'd2;
  localparam logic [1:0] c_row_slot = 2'd1;
`else
  localparam logic [1:0] c_lat_last = 2'd1;
  localparam logic [1:0] c_row_slot = 2'd0;
`endif
  localparam logic [7:0]       c_cols     = 8'(COLS);
  localparam logic [7:0]       c_pwm_max  = 8'(PWM_MAX);
  localparam logic [ROW_W-1:0] c_last_row = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] c_row_one  = ROW_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RRST  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       col_q, col_d;
  logic [1:0]       lat_q, lat_d;
  logic [ROW_W-1:0] shift_row_q, shift_row_d;
  logic [ROW_W-1:0] row_addr_q, row_addr_d;
  logic [7:0]       pwm_q, pwm_d;
  logic             first_q, first_d;
  logic             al_re_n_q, al_re_n_d;
  logic             al_rrst_n_q, al_rrst_n_d;
  logic             panel_clk_en_q, panel_clk_en_d;
  logic             led_lat_q, led_lat_d;
  logic             led_oe_n_q, led_oe_n_d;
  logic             frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    lat_d        = lat_q;
    shift_row_d  = shift_row_q;
    first_d      = first_q;
    pwm_d        = pwm_q;
    frame_done_d = 1'b0;

    // first_q marks the rewind that follows IDLE; it must not step the PWM.
    if (state_q == RRST && scan.alrst_strobe && !first_q)
      pwm_d = (pwm_q == c_pwm_max) ? 8'd0 : pwm_q + 8'd1;

    if (scan.pwm_cntr_strobe) begin
      case (state_q)
        IDLE: begin
          if (scan.en) state_d = RRST;
        end
        RRST: begin
          state_d     = SHIFT;
          col_d       = 8'd0;
          shift_row_d = '0;
          first_d     = 1'b0;
        end
        SHIFT: begin
          if (col_q == c_cols) begin
            state_d = LATCH;
            lat_d   = 2'd0;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
        LATCH: begin
          if (lat_q != c_lat_last) begin
            lat_d = lat_q + 2'd1;
          end else if (shift_row_q != c_last_row) begin
            shift_row_d = shift_row_q + c_row_one;
            col_d       = 8'd0;
            state_d     = SHIFT;
          end else begin
            frame_done_d = 1'b1;
            if (scan.en) begin
              state_d = RRST;
            end else begin
              state_d = IDLE;
              first_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register on the slot edge.
    al_rrst_n_d    = (state_d != RRST);
    al_re_n_d      = !(state_d == SHIFT && col_d != c_cols);
    panel_clk_en_d = (state_d == SHIFT && col_d != 8'd0);
    led_oe_n_d     = (state_d != SHIFT);
    led_lat_d      = (state_d == LATCH && lat_d == 2'd0);
    row_addr_d     = row_addr_q;
    if (state_d == LATCH && lat_d == c_row_slot) row_addr_d = shift_row_d;
  end

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state_q        <= IDLE;
      col_q          <= 8'd0;
      lat_q          <= 2'd0;
      shift_row_q    <= '0;
      row_addr_q     <= '0;
      pwm_q          <= 8'd0;
      first_q        <= 1'b1;
      al_re_n_q      <= 1'b1;
      al_rrst_n_q    <= 1'b1;
      panel_clk_en_q <= 1'b0;
      led_lat_q      <= 1'b0;
      led_oe_n_q     <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      lat_q          <= lat_d;
      shift_row_q    <= shift_row_d;
      row_addr_q     <= row_addr_d;
      pwm_q          <= pwm_d;
      first_q        <= first_d;
      al_re_n_q      <= al_re_n_d;
      al_rrst_n_q    <= al_rrst_n_d;
      panel_clk_en_q <= panel_clk_en_d;
      led_lat_q      <= led_lat_d;
      led_oe_n_q     <= led_oe_n_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign scan.pwm_value    = pwm_q;
  assign scan.al_re_n      = al_re_n_q;
  assign scan.al_rrst_n    = al_rrst_n_q;
  assign scan.panel_clk_en = panel_clk_en_q;
  assign scan.led_lat      = led_lat_q;
  assign scan.led_oe_n     = led_oe_n_q;
  assign scan.row_addr     = row_addr_q;
  assign scan.frame_done   = frame_done_q;
endmodule
`default_nettype wire
